// File: rtl/q_user_rx.sv
// q_user_rx: receive-side unpacker for the 32-bit user_t link.
// Pairs key/value beats into 64-bit user_t entries and buffers them in a
// small FIFO. It also flags framing errors and counts errors and deliveries.

package q_pkg;
  localparam int USER_W = 64;
  typedef struct packed {
    logic [31:0] k;
    logic [31:0] v;
  } user_t;
endpackage

module q_user_rx #(
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic                 in_first,
  input  logic [31:0]          in_data,
  output logic                 in_rdy,
  output logic                 out_vld,
  output q_pkg::user_t         out_data,
  input  logic                 out_rdy,
  output logic                 err_framing,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     out_cnt
);

  localparam int AW    = $clog2(OUT_DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [0:0] ST_KEY = 1'b0;
  localparam logic [0:0] ST_VAL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      key_q, key_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  q_pkg::user_t     mem [OUT_DEPTH];

  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic             frame_err;

  // Handshake decode; in_rdy depends only on registered state and pointers
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_rdy     = (state_q == ST_KEY) || !fifo_full;
    out_vld    = !fifo_empty;
    accept     = in_vld && in_rdy;
    push       = accept && (state_q == ST_VAL) && !in_first;
    pop        = out_vld && out_rdy;
    frame_err  = accept && (((state_q == ST_KEY) && !in_first) ||
                            ((state_q == ST_VAL) &&  in_first));
  end

  // Next-state: framing FSM, key capture, FIFO pointers and counters
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = frame_err;
    err_cnt_d = err_cnt_q;
    out_cnt_d = out_cnt_q;

    // Any accepted key (first or duplicate) replaces the held key
    if (accept && in_first) begin
      key_d   = in_data;
      state_d = ST_VAL;
    end else if (push) begin
      state_d = ST_KEY;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (frame_err && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
    if (pop)
      out_cnt_d = out_cnt_q + CNT_W'(1);
  end

  // Control registers; reset drops any partial key and all FIFO contents
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_KEY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Data registers: held key and FIFO storage, qualified by control only
  always_ff @(posedge clk) begin
    key_q <= key_d;
    if (push) mem[wr_ptr_q[AW-1:0]] <= '{k: key_q, v: in_data};
  end

  assign out_data    = mem[rd_ptr_q[AW-1:0]];
  assign err_framing = err_q;
  assign err_cnt     = err_cnt_q;
  assign out_cnt     = out_cnt_q;

endmodule

// File: tb/tb_q_user_rx.sv
// Directed bench for q_user_rx: basic pairing, streaming, back-pressure,
// framing errors, counter saturation/wrap and reset mid-entry.
module tb_q_user_rx;

  localparam int CNT_W = 4;

  logic         clk;
  logic         rst;
  logic         in_vld;
  logic         in_first;
  logic [31:0]  in_data;
  logic         in_rdy;
  logic         out_vld;
  q_pkg::user_t out_data;
  logic         out_rdy;
  logic         err_framing;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] out_cnt;

  int total = 0;
  int bad   = 0;

  q_user_rx #(.OUT_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_first    (in_first),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .out_rdy     (out_rdy),
    .err_framing (err_framing),
    .err_cnt     (err_cnt),
    .out_cnt     (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven, advance past the edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic [31:0] d);
    in_vld   = 1'b1;
    in_first = f;
    in_data  = d;
    tick();
    in_vld   = 1'b0;
    in_first = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    int rdy_low;
    rst = 1'b1; in_vld = 1'b0; in_first = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_err_framing", 64'(err_framing), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    rst = 1'b0;

    // Basic entry
    out_rdy = 1'b1;
    beat(1'b1, 32'h0000_0011);
    chk("basic_no_out_after_key", 64'(out_vld), 64'd0);
    beat(1'b0, 32'hDEAD_BEEF);
    chk("basic_out_vld", 64'(out_vld), 64'd1);
    chk("basic_out_data", out_data, 64'h0000_0011_DEAD_BEEF);
    chk("basic_no_err", 64'(err_framing), 64'd0);
    tick();
    chk("basic_out_cnt", 64'(out_cnt), 64'd1);
    chk("basic_drained", 64'(out_vld), 64'd0);
    chk("basic_err_cnt", 64'(err_cnt), 64'd0);

    // Streaming 8 entries back to back
    rdy_low = 0;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 32'(i));
      if (!in_rdy) rdy_low++;
      beat(1'b0, 32'h100 + 32'(i));
      if (!in_rdy) rdy_low++;
      chk("stream_out_vld", 64'(out_vld), 64'd1);
      chk("stream_out_data", out_data, {32'(i), 32'h100 + 32'(i)});
    end
    tick();
    chk("stream_in_rdy_never_low", 64'(rdy_low), 64'd0);
    chk("stream_out_cnt", 64'(out_cnt), 64'd9);

    // Back-pressure with a 2-entry FIFO
    out_rdy = 1'b0;
    beat(1'b1, 32'd0);
    beat(1'b0, 32'h100);
    beat(1'b1, 32'd1);
    beat(1'b0, 32'h101);
    chk("bp_in_rdy_key_state", 64'(in_rdy), 64'd1);
    beat(1'b1, 32'd2);
    chk("bp_in_rdy_low", 64'(in_rdy), 64'd0);
    chk("bp_head0", out_data, {32'd0, 32'h100});
    in_vld = 1'b1; in_first = 1'b0; in_data = 32'h102;
    tick();
    chk("bp_stall_in_rdy", 64'(in_rdy), 64'd0);
    chk("bp_hold_data", out_data, {32'd0, 32'h100});
    out_rdy = 1'b1;
    tick();
    chk("bp_rdy_after_pop", 64'(in_rdy), 64'd1);
    chk("bp_head1", out_data, {32'd1, 32'h101});
    tick();
    in_vld = 1'b0; in_data = '0;
    chk("bp_head2_vld", 64'(out_vld), 64'd1);
    chk("bp_head2", out_data, {32'd2, 32'h102});
    tick();
    chk("bp_drained", 64'(out_vld), 64'd0);
    chk("bp_out_cnt", 64'(out_cnt), 64'd12);

    // Framing errors
    beat(1'b0, 32'h5);
    chk("orphan_pulse", 64'(err_framing), 64'd1);
    chk("orphan_err_cnt", 64'(err_cnt), 64'd1);
    chk("orphan_no_out", 64'(out_vld), 64'd0);
    tick();
    chk("orphan_pulse_end", 64'(err_framing), 64'd0);
    beat(1'b1, 32'hA);
    chk("dup_first_ok", 64'(err_framing), 64'd0);
    beat(1'b1, 32'hB);
    chk("dup_pulse", 64'(err_framing), 64'd1);
    chk("dup_err_cnt", 64'(err_cnt), 64'd2);
    beat(1'b0, 32'hC);
    chk("dup_no_err_on_val", 64'(err_framing), 64'd0);
    chk("dup_out_vld", 64'(out_vld), 64'd1);
    chk("dup_out_data", out_data, 64'h0000_000B_0000_000C);
    // Orphan beat coincides with the pop of the entry above
    beat(1'b0, 32'hEE);
    chk("both_err_cnt", 64'(err_cnt), 64'd3);
    chk("both_out_cnt", 64'(out_cnt), 64'd13);
    chk("both_out_vld", 64'(out_vld), 64'd0);

    // Error counter saturation
    for (int i = 0; i < 20; i++) beat(1'b0, 32'(i));
    chk("sat_pulse", 64'(err_framing), 64'd1);
    chk("sat_err_cnt", 64'(err_cnt), 64'd15);

    // Delivery counter wrap from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err_cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 17; i++) begin
      beat(1'b1, 32'(i));
      beat(1'b0, 32'h200 + 32'(i));
    end
    tick();
    chk("wrap_out_cnt", 64'(out_cnt), 64'd1);
    chk("wrap_err_cnt", 64'(err_cnt), 64'd0);

    // Reset mid-entry with one entry buffered
    out_rdy = 1'b0;
    beat(1'b1, 32'h1);
    beat(1'b0, 32'h2);
    chk("mid_buffered", 64'(out_vld), 64'd1);
    beat(1'b1, 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_fifo_empty", 64'(out_vld), 64'd0);
    chk("mid_in_rdy", 64'(in_rdy), 64'd1);
    chk("mid_no_err", 64'(err_framing), 64'd0);
    chk("mid_out_cnt", 64'(out_cnt), 64'd0);
    beat(1'b0, 32'h9);
    chk("mid_orphan_pulse", 64'(err_framing), 64'd1);
    chk("mid_err_cnt", 64'(err_cnt), 64'd1);
    chk("mid_no_out", 64'(out_vld), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
